// File: rtl/dtu_output_scheduler.sv
// Purpose: picks idle, sync or data/test words for the four output serializers.
// Latency: inputs sampled on a handshake cycle appear on DATA32_OUT_x the next cycle.
// Backpressure: none; the serializer handshake paces every change, and words are held between handshakes.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   handshake              serializers latch the next word in this cycle
//   CALIBRATION_BUSY       ADC calibration running, forces idle words
//   TEST_ENABLE            forward ADC-test-unit words instead of datapath words
//   SYNC_REQ               pulse requesting a training sequence
//   DATA32_x, DATA32_ATU_x datapath and ADC test unit words, lanes 0..3
//   DATA32_OUT_x           registered words to the serializers
//   sync_done, state       training complete flag, FSM state
//   load_cnt               wrapping count of data/test word loads
module dtu_output_scheduler #(
  parameter logic [31:0] IDLE_PATTERN  = 32'hEAAAAAAA,
  parameter logic [31:0] SYNC_PATTERN  = 32'h5A5A5A5A,
  parameter int unsigned SYNC_WORDS    = 64,
  parameter int unsigned SYNC_CNT_BITS = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        handshake,
  input  logic        CALIBRATION_BUSY,
  input  logic        TEST_ENABLE,
  input  logic        SYNC_REQ,
  input  logic [31:0] DATA32_0,
  input  logic [31:0] DATA32_1,
  input  logic [31:0] DATA32_2,
  input  logic [31:0] DATA32_3,
  input  logic [31:0] DATA32_ATU_0,
  input  logic [31:0] DATA32_ATU_1,
  input  logic [31:0] DATA32_ATU_2,
  input  logic [31:0] DATA32_ATU_3,
  output logic [31:0] DATA32_OUT_0,
  output logic [31:0] DATA32_OUT_1,
  output logic [31:0] DATA32_OUT_2,
  output logic [31:0] DATA32_OUT_3,
  output logic        sync_done,
  output logic [2:0]  state,
  output logic [15:0] load_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_TEST  = 3'd3,
    ST_CALIB = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SYNC = 2'd1,
    W_DATA = 2'd2,
    W_ATU  = 2'd3
  } word_sel_t;

  localparam logic [SYNC_CNT_BITS-1:0] SYNC_LAST = SYNC_CNT_BITS'(SYNC_WORDS);
  localparam logic [SYNC_CNT_BITS-1:0] SYNC_ONE  = SYNC_CNT_BITS'(1);

  state_t                   state_q, state_d;
  word_sel_t                word_sel;
  logic [SYNC_CNT_BITS-1:0] sync_cnt_q, sync_cnt_d;
  logic                     sync_done_q, sync_done_d;
  logic                     sync_pend_q;
  logic [15:0]              load_cnt_q;
  logic                     enter_sync, load_word;
  logic [31:0]              data_w [4];
  logic [31:0]              atu_w  [4];
  logic [31:0]              out_q  [4];
  logic [31:0]              out_d  [4];

  assign data_w[0] = DATA32_0;
  assign data_w[1] = DATA32_1;
  assign data_w[2] = DATA32_2;
  assign data_w[3] = DATA32_3;
  assign atu_w[0]  = DATA32_ATU_0;
  assign atu_w[1]  = DATA32_ATU_1;
  assign atu_w[2]  = DATA32_ATU_2;
  assign atu_w[3]  = DATA32_ATU_3;

  // Decision taken on a handshake. enter_sync / load_word are the two shared
  // actions reachable from several states; they are applied after the case.
  always_comb begin
    state_d     = state_q;
    word_sel    = W_IDLE;
    sync_cnt_d  = sync_cnt_q;
    sync_done_d = sync_done_q;
    enter_sync  = 1'b0;
    load_word   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CALIB: begin
        if (CALIBRATION_BUSY)  state_d = ST_CALIB;
        else if (sync_pend_q)  enter_sync = 1'b1;
        else if (sync_done_q)  load_word = 1'b1;
        else                   state_d = ST_IDLE;
      end
      ST_SYNC: begin
        if (CALIBRATION_BUSY) begin
          state_d    = ST_CALIB;
          sync_cnt_d = '0;
        end else if (sync_cnt_q < SYNC_LAST) begin
          word_sel   = W_SYNC;
          sync_cnt_d = sync_cnt_q + SYNC_ONE;
        end else begin
          // Last training word already sent: first data words go out now.
          sync_done_d = 1'b1;
          sync_cnt_d  = '0;
          load_word   = 1'b1;
        end
      end
      ST_DATA, ST_TEST: begin
        if (CALIBRATION_BUSY)  state_d = ST_CALIB;
        else if (sync_pend_q)  enter_sync = 1'b1;
        else                   load_word = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_sync) begin
      state_d     = ST_SYNC;
      word_sel    = W_SYNC;
      sync_cnt_d  = SYNC_ONE;
      sync_done_d = 1'b0;
    end
    if (load_word) begin
      state_d  = TEST_ENABLE ? ST_TEST : ST_DATA;
      word_sel = TEST_ENABLE ? W_ATU : W_DATA;
    end

    for (int i = 0; i < 4; i++) begin
      unique case (word_sel)
        W_SYNC:  out_d[i] = SYNC_PATTERN;
        W_DATA:  out_d[i] = data_w[i];
        W_ATU:   out_d[i] = atu_w[i];
        default: out_d[i] = IDLE_PATTERN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      sync_cnt_q  <= '0;
      sync_done_q <= 1'b0;
      sync_pend_q <= 1'b0;
      load_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= IDLE_PATTERN;
    end else begin
      if (handshake) begin
        state_q     <= state_d;
        sync_cnt_q  <= sync_cnt_d;
        sync_done_q <= sync_done_d;
        if (load_word) load_cnt_q <= load_cnt_q + 16'd1;
        for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
      end
      // A request arriving on the very cycle SYNC is entered is absorbed by
      // that entry; requests during SYNC are dropped.
      if (handshake && enter_sync)
        sync_pend_q <= 1'b0;
      else if (SYNC_REQ && (state_q != ST_SYNC))
        sync_pend_q <= 1'b1;
    end
  end

  assign DATA32_OUT_0 = out_q[0];
  assign DATA32_OUT_1 = out_q[1];
  assign DATA32_OUT_2 = out_q[2];
  assign DATA32_OUT_3 = out_q[3];
  assign sync_done    = sync_done_q;
  assign state        = state_q;
  assign load_cnt     = load_cnt_q;

endmodule

// File: tb/tb_dtu_output_scheduler.sv
// Purpose: self-checking bench for dtu_output_scheduler (SYNC_WORDS=4).
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: n/a; handshake is driven directly by the bench.
module tb_dtu_output_scheduler;

  localparam int          SW    = 4;
  localparam logic [31:0] IDLEP = 32'hEAAAAAAA;
  localparam logic [31:0] SYNCP = 32'h5A5A5A5A;

  logic        CLK, RST, hs, busy, te, req;
  logic [31:0] dat [4];
  logic [31:0] atu [4];
  logic [31:0] o0, o1, o2, o3;
  logic        sync_done;
  logic [2:0]  state;
  logic [15:0] load_cnt;

  int n_checks = 0;
  int n_err    = 0;

  dtu_output_scheduler #(
    .IDLE_PATTERN (IDLEP),
    .SYNC_PATTERN (SYNCP),
    .SYNC_WORDS   (SW),
    .SYNC_CNT_BITS(3)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .handshake       (hs),
    .CALIBRATION_BUSY(busy),
    .TEST_ENABLE     (te),
    .SYNC_REQ        (req),
    .DATA32_0        (dat[0]),
    .DATA32_1        (dat[1]),
    .DATA32_2        (dat[2]),
    .DATA32_3        (dat[3]),
    .DATA32_ATU_0    (atu[0]),
    .DATA32_ATU_1    (atu[1]),
    .DATA32_ATU_2    (atu[2]),
    .DATA32_ATU_3    (atu[3]),
    .DATA32_OUT_0    (o0),
    .DATA32_OUT_1    (o1),
    .DATA32_OUT_2    (o2),
    .DATA32_OUT_3    (o3),
    .sync_done       (sync_done),
    .state           (state),
    .load_cnt        (load_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                           input logic dn, input logic [15:0] ld);
    chk({tag, " state"}, {29'd0, state}, {29'd0, st});
    chk({tag, " out0"}, o0, w0);
    chk({tag, " out1"}, o1, w1);
    chk({tag, " out2"}, o2, w2);
    chk({tag, " out3"}, o3, w3);
    chk({tag, " sync_done"}, {31'd0, sync_done}, {31'd0, dn});
    chk({tag, " load_cnt"}, {16'd0, load_cnt}, {16'd0, ld});
  endtask

  task automatic check_reset(input string tag);
    check_all(tag, 3'd0, IDLEP, IDLEP, IDLEP, IDLEP, 1'b0, 16'd0);
  endtask

  // ---------------- reference model ----------------
  // Kept as "what the serializers should be seeing": a mode number, how many
  // training words have gone out, and the four held words.
  int          m_mode;
  int          m_sent;
  bit          m_done, m_pend;
  logic [31:0] m_w [4];
  logic [15:0] m_load;

  task automatic m_fill(input logic [31:0] v);
    for (int i = 0; i < 4; i++) m_w[i] = v;
  endtask

  task automatic m_load_words();
    m_mode = te ? 3 : 2;
    for (int i = 0; i < 4; i++) m_w[i] = te ? atu[i] : dat[i];
    m_load = m_load + 16'd1;
  endtask

  // Applies the currently driven inputs as one clock edge.
  task automatic model_step();
    int prev;
    bit entered;
    if (RST) begin
      m_mode = 0; m_sent = 0; m_done = 0; m_pend = 0; m_load = 0;
      m_fill(IDLEP);
      return;
    end
    prev = m_mode;
    entered = 0;
    if (hs) begin
      if (busy) begin
        m_mode = 4; m_sent = 0; m_fill(IDLEP);
      end else if (m_mode == 1) begin
        if (m_sent < SW) begin
          m_sent++; m_fill(SYNCP);
        end else begin
          m_done = 1; m_load_words();
        end
      end else if (m_pend) begin
        m_mode = 1; m_sent = 1; m_done = 0; m_fill(SYNCP); entered = 1;
      end else if (m_done) begin
        m_load_words();
      end else begin
        m_mode = 0; m_fill(IDLEP);
      end
    end
    if (entered) m_pend = 0;
    else if (req && prev != 1) m_pend = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          hs, busy, te, req;
    logic [2:0]  st;
    bit          dn;
    logic [15:0] ld;
  } vec_t;

  vec_t tab [30];

  function automatic logic [31:0] tab_word(input logic [2:0] st, input int i);
    case (st)
      3'd1:    return SYNCP;
      3'd2:    return 32'h12345678 + i;
      3'd3:    return 32'hA5000000 + i;
      default: return IDLEP;
    endcase
  endfunction

  initial begin
    logic [31:0] hold [4];
    RST = 1'b1; hs = 0; busy = 0; te = 0; req = 0;
    for (int i = 0; i < 4; i++) begin
      dat[i] = 32'h12345678 + i;
      atu[i] = 32'hA5000000 + i;
    end

    // hs busy te req | state done load
    for (int i = 0; i < 5; i++) tab[i] = '{1, 0, 0, 0, 3'd0, 0, 16'd0};
    tab[5]  = '{0, 0, 0, 1, 3'd0, 0, 16'd0};
    tab[6]  = '{0, 0, 0, 0, 3'd0, 0, 16'd0};
    tab[7]  = '{1, 0, 0, 0, 3'd1, 0, 16'd0};
    tab[8]  = '{0, 0, 0, 0, 3'd1, 0, 16'd0};
    tab[9]  = '{1, 0, 0, 0, 3'd1, 0, 16'd0};
    tab[10] = '{1, 0, 0, 0, 3'd1, 0, 16'd0};
    tab[11] = '{1, 0, 0, 0, 3'd1, 0, 16'd0};
    tab[12] = '{1, 0, 0, 0, 3'd2, 1, 16'd1};
    tab[13] = '{0, 0, 1, 0, 3'd2, 1, 16'd1};
    tab[14] = '{1, 0, 1, 0, 3'd3, 1, 16'd2};
    tab[15] = '{1, 0, 0, 0, 3'd2, 1, 16'd3};
    tab[16] = '{1, 1, 0, 0, 3'd4, 1, 16'd3};
    tab[17] = '{1, 0, 0, 0, 3'd2, 1, 16'd4};
    tab[18] = '{0, 0, 0, 1, 3'd2, 1, 16'd4};
    tab[19] = '{1, 0, 0, 0, 3'd1, 0, 16'd4};
    tab[20] = '{1, 0, 0, 0, 3'd1, 0, 16'd4};
    tab[21] = '{1, 1, 0, 0, 3'd4, 0, 16'd4};
    tab[22] = '{1, 0, 0, 0, 3'd0, 0, 16'd4};
    tab[23] = '{0, 0, 0, 1, 3'd0, 0, 16'd4};
    tab[24] = '{1, 0, 0, 0, 3'd1, 0, 16'd4};
    tab[25] = '{1, 0, 0, 1, 3'd1, 0, 16'd4};
    tab[26] = '{1, 0, 0, 0, 3'd1, 0, 16'd4};
    tab[27] = '{1, 0, 0, 0, 3'd1, 0, 16'd4};
    tab[28] = '{1, 0, 0, 0, 3'd2, 1, 16'd5};
    tab[29] = '{1, 0, 0, 0, 3'd2, 1, 16'd6};

    // Reset state
    tick(); tick();
    check_reset("reset");
    RST = 1'b0;

    // Table vectors
    for (int v = 0; v < 30; v++) begin
      hs = tab[v].hs; busy = tab[v].busy; te = tab[v].te; req = tab[v].req;
      tick();
      check_all($sformatf("vec%0d", v), tab[v].st,
                tab_word(tab[v].st, 0), tab_word(tab[v].st, 1),
                tab_word(tab[v].st, 2), tab_word(tab[v].st, 3),
                tab[v].dn, tab[v].ld);
    end

    // SYNC_REQ held with no handshake: nothing moves, even with new input words
    for (int i = 0; i < 4; i++) hold[i] = dat[i];
    hs = 0; req = 1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) dat[i] = $urandom;
      tick();
      check_all($sformatf("nohs%0d", c), 3'd2, hold[0], hold[1], hold[2], hold[3], 1'b1, 16'd6);
    end
    req = 0; hs = 1;
    tick();
    check_all("hs_after_wait", 3'd1, SYNCP, SYNCP, SYNCP, SYNCP, 1'b0, 16'd6);

    // Reset during SYNC
    hs = 0; RST = 1;
    tick();
    check_reset("rst_in_sync");
    RST = 0;

    // Reach DATA again, then reset during DATA
    req = 1; tick(); req = 0; hs = 1;
    for (int c = 0; c < SW + 1; c++) tick();
    check_all("redata", 3'd2, dat[0], dat[1], dat[2], dat[3], 1'b1, 16'd1);
    hs = 0; RST = 1;
    tick();
    check_reset("rst_in_data");

    // Randomised run against the model
    model_step();
    RST = 0;
    for (int c = 0; c < 4000; c++) begin
      RST  = ($urandom_range(0, 299) == 0);
      hs   = ($urandom_range(0, 2) == 0);
      busy = ($urandom_range(0, 9) == 0);
      req  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) te = ~te;
      for (int i = 0; i < 4; i++) begin
        dat[i] = $urandom;
        atu[i] = $urandom;
      end
      model_step();
      tick();
      check_all($sformatf("rnd%0d", c), m_mode[2:0], m_w[0], m_w[1], m_w[2], m_w[3],
                m_done, m_load);
    end

    // load_cnt wrap: 65535 loads reach 16'hFFFF, the next load gives 0
    RST = 1; hs = 0; busy = 0; te = 0; req = 0;
    tick();
    RST = 0; req = 1;
    tick();
    req = 0; hs = 1;
    for (int c = 0; c < SW + 1; c++) tick();
    for (int c = 0; c < 65534; c++) tick();
    chk("wrap_ffff", {16'd0, load_cnt}, 32'h0000FFFF);
    tick();
    chk("wrap_zero", {16'd0, load_cnt}, 32'h00000000);
    chk("wrap_state", {29'd0, state}, 32'd2);
    hs = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dtu_output_scheduler.md
Name: dtu_output_scheduler

Overview:
- Sequences the four 32-bit words presented to the LiTE-DTU output serializers.
- Selects, per serializer load, one of three sources:
  - the idle pattern,
  - the link-training sync pattern,
  - the datapath words (normal) or ADC-test-unit words (test).
- All source changes happen only on serializer handshake boundaries, so a serializer never sees a word torn mid-shift.
- Sits between the datapath/ADC test unit outputs and the serializer inputs.

Parameters:
- IDLE_PATTERN, 32'hEAAAAAAA, word sent when no data may be sent.
- SYNC_PATTERN, 32'h5A5A5A5A, training word sent during synchronisation.
- SYNC_WORDS, 64, number of sync words per training sequence (≥1).
- SYNC_CNT_BITS, 7, counter width; must hold SYNC_WORDS.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous reset, active-high
- handshake  input  1  one-cycle pulse from serializers: next word is latched now
- CALIBRATION_BUSY  input  1  ADC calibration in progress (level)
- TEST_ENABLE  input  1  1 = forward ADC-test-unit words instead of datapath words (level)
- SYNC_REQ  input  1  one-cycle request to start a training sequence
- DATA32_0..DATA32_3  input  32 each  datapath words
- DATA32_ATU_0..DATA32_ATU_3  input  32 each  ADC test unit words
- DATA32_OUT_0..DATA32_OUT_3  output  32 each  words to serializers (registered)
- sync_done  output  1  training sequence completed since last reset/resync
- state  output  3  FSM state: IDLE=0, SYNC=1, DATA=2, TEST=3, CALIB=4
- load_cnt  output  16  count of data/test word loads, wraps 16'hFFFF→0

Behaviour:
- Clock, reset and reset values:
  - Single clock CLK; synchronous active-high reset RST.
  - On RST: state=IDLE, all DATA32_OUT_x=IDLE_PATTERN, sync_done=0, load_cnt=0, sync counter=0, sync-pending flag=0.
  - RST mid-sequence aborts immediately, with the same values.
- Sync-pending flag:
  - Set by SYNC_REQ in any state except SYNC; SYNC_REQ during SYNC is ignored.
  - Cleared on the cycle the FSM enters SYNC. SYNC_REQ coincident with that entry is consumed, not re-latched.
- Update timing:
  - State and outputs change only in a cycle with handshake=1.
  - Inputs are sampled in that cycle; the new words are visible on DATA32_OUT_x from the next cycle and held until the next handshake.
  - No handshake means no change, regardless of other inputs (the sync-pending flag still latches).
- Decision priority on each handshake: CALIBRATION_BUSY > sync pending > TEST_ENABLE > normal.
- IDLE:
  - CALIBRATION_BUSY → CALIB, output idle.
  - Else pending → SYNC, output SYNC_PATTERN, cnt=1.
  - Else if sync_done → TEST/DATA per TEST_ENABLE, loading the corresponding words.
  - Else stay IDLE, output idle.
- SYNC:
  - CALIBRATION_BUSY → CALIB, output idle, sync_done stays 0, cnt=0.
  - Else if cnt<SYNC_WORDS → output SYNC_PATTERN, cnt++.
  - Else (cnt==SYNC_WORDS) → sync_done=1, cnt=0, go TEST/DATA per TEST_ENABLE, loading first data words in this same handshake.
  - Exactly SYNC_WORDS sync words are emitted.
- DATA/TEST:
  - CALIBRATION_BUSY → CALIB, output idle.
  - Else pending → SYNC, sync_done=0, output SYNC_PATTERN, cnt=1.
  - Else load DATA32_x (TEST_ENABLE=0, state DATA) or DATA32_ATU_x (TEST_ENABLE=1, state TEST), load_cnt++.
  - A TEST_ENABLE change takes effect at the next handshake; no intermediate word.
- CALIB:
  - Output idle while CALIBRATION_BUSY=1.
  - On handshake with CALIBRATION_BUSY=0:
    - pending → SYNC;
    - else sync_done → TEST/DATA, loading words;
    - else IDLE, output idle.
- load_cnt: increments only on DATA/TEST word loads (including the first load on leaving SYNC/IDLE/CALIB); no saturation.
- Output channels 0..3 are always switched together.

Test Plan:
- Reset, 5 handshakes, no SYNC_REQ → all outputs 32'hEAAAAAAA, state=0, sync_done=0, load_cnt=0.
- SYNC_REQ pulse, then handshakes every 4 cycles, SYNC_WORDS=4:
  - handshakes 1–4 output 32'h5A5A5A5A;
  - handshake 5 outputs DATA32_x (e.g. 32'h12345678), sync_done=1, state=2, load_cnt=1.
- In DATA, raise TEST_ENABLE mid-interval → outputs unchanged until next handshake, then DATA32_ATU_x; state=3. Lower it → DATA32_x at the following handshake.
- CALIBRATION_BUSY=1 during SYNC after 2 sync words → next handshake idle, state=4, sync_done=0. Release with no pending request → next handshake state=0, idle output. SYNC_REQ then yields a full 4-word sync.
- SYNC_REQ asserted with no handshake for 10 cycles → outputs and state unchanged. Next handshake → SYNC entered; a second SYNC_REQ inside SYNC is ignored (exactly 4 sync words, then data).
- RST asserted for 1 cycle during SYNC or DATA → next cycle outputs idle, state=0, sync_done=0, load_cnt=0. Wrap check: load_cnt preset to 16'hFFFF by 65535 loads, next load gives 0.
